alu_seq_ctrl: RTL

- Multi-cycle control FSM that sequences the register file / ALU datapath.
- Accepts one 16-bit instruction at a time over a valid/ready handshake and decodes it.
- Drives the datapath controls: regEnable, a_select, b_select, use_imm, immediate, opCode.
- Reports completion, a retired-instruction count and a sticky illegal-instruction error.

---
 rtl/alu_seq_ctrl_if.sv | 48 ++++
 rtl/alu_seq_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl_if
//   Bundles the instruction handshake and the datapath control/status signals
//   of alu_seq_ctrl.
//   master : instruction source; drives instr/instr_valid, observes the rest.
//   slave  : the controller; accepts instructions, drives controls and status.
//   Signals:
//     instr[15:0]      instruction word
//     instr_valid      instr is valid
//     instr_ready      controller can accept an instruction
//     regEnable[15:0]  one-hot register write enable
//     a_select[3:0]    A-operand mux select
//     b_select[3:0]    B-operand mux select
//     use_imm          use immediate instead of mux B output
//     immediate[15:0]  extended immediate
//     opCode[7:0]      ALU opcode
//     done             one-cycle completion pulse
//     err              sticky illegal-instruction flag
//     retired          count of legal instructions executed
// ---------------------------------------------------------------------------
interface alu_seq_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [15:0]      instr;
    logic             instr_valid;
    logic             instr_ready;
    logic [15:0]      regEnable;
    logic [3:0]       a_select;
    logic [3:0]       b_select;
    logic             use_imm;
    logic [15:0]      immediate;
    logic [7:0]       opCode;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] retired;

    modport master (
        output instr, instr_valid,
        input  instr_ready, regEnable, a_select, b_select, use_imm,
               immediate, opCode, done, err, retired
    );

    modport slave (
        input  instr, instr_valid,
        output instr_ready, regEnable, a_select, b_select, use_imm,
               immediate, opCode, done, err, retired
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl
//   Four-state control FSM (IDLE -> DECODE -> EXEC -> DONE) that accepts one
//   16-bit instruction per handshake, decodes it, drives the register file /
//   ALU controls for one EXEC cycle, then pulses done and updates the
//   retired-instruction counter or the sticky error flag.
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous, active-high; clears all state
//     bus    alu_seq_ctrl_if.slave (handshake, datapath controls, status)
// ---------------------------------------------------------------------------
module alu_seq_ctrl #(
    parameter logic [7:0] NOP_OP = 8'h00,
    parameter int         CNT_W  = 16
) (
    input  logic          clk,
    input  logic          reset,
    alu_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [15:0]      r_instr;
    logic [3:0]       r_func;
    logic [3:0]       r_a_sel;
    logic [3:0]       r_b_sel;
    logic             r_use_imm;
    logic [15:0]      r_imm;
    logic [15:0]      r_reg_en;
    logic             r_legal;
    logic             r_err;
    logic [CNT_W-1:0] r_retired;

    logic [3:0]       w_op;
    logic [3:0]       w_func;
    logic             w_legal;
    logic             w_zext;
    logic [15:0]      w_imm;
    logic [15:0]      w_reg_en;

    // Decode works only from the latched instruction, so every datapath
    // control is a function of registered state, never of the live bus.
    assign w_op   = r_instr[15:12];
    assign w_func = (w_op == 4'h0) ? r_instr[7:4] : w_op;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_legal = 1'b0;
        w_zext  = 1'b0;
        case (w_func)
            4'h1, 4'h2, 4'h3, 4'hD: begin
                w_legal = 1'b1;
                w_zext  = 1'b1;
            end
            4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB: w_legal = 1'b1;
            default: ;
        endcase
    end

    // RR form carries no immediate; logic ops and MOV zero-extend, the
    // arithmetic group sign-extends.
    assign w_imm = (w_op == 4'h0) ? 16'h0000 :
                   w_zext         ? {8'h00, r_instr[7:0]} :
                                    {{8{r_instr[7]}}, r_instr[7:0]};

    // CMP only sets flags and illegal instructions must not write back.
    assign w_reg_en = (w_legal && (w_func != 4'hB)) ? (16'h0001 << r_instr[11:8])
                                                    : 16'h0000;

    // NOTE: all control registers here are small flops, so every one of them
    // is cleared by reset; nothing is left to power-up state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_instr   <= 16'h0000;
            r_func    <= 4'h0;
            r_a_sel   <= 4'h0;
            r_b_sel   <= 4'h0;
            r_use_imm <= 1'b0;
            r_imm     <= 16'h0000;
            r_reg_en  <= 16'h0000;
            r_legal   <= 1'b0;
            r_err     <= 1'b0;
            r_retired <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            r_state <= w_next_state;
            if (r_state == S_IDLE && bus.instr_valid) begin
                r_instr <= bus.instr;
            end
            if (r_state == S_DECODE) begin
                r_func    <= w_func;
                r_a_sel   <= r_instr[11:8];
                r_b_sel   <= (w_op == 4'h0) ? r_instr[3:0] : 4'h0;
                r_use_imm <= (w_op != 4'h0);
                r_imm     <= w_imm;
                r_reg_en  <= w_reg_en;
                r_legal   <= w_legal;
            end
            if (r_state == S_DONE) begin
                if (r_legal) begin
                    r_retired <= r_retired + CNT_W'(1);
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_next_state    = r_state;
        bus.instr_ready = 1'b0;
        bus.regEnable   = 16'h0000;
        bus.a_select    = 4'h0;
        bus.b_select    = 4'h0;
        bus.use_imm     = 1'b0;
        bus.immediate   = 16'h0000;
        bus.opCode      = NOP_OP;
        bus.done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.instr_ready = 1'b1;
                if (bus.instr_valid) begin
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: w_next_state = S_EXEC;
            S_EXEC: begin
                bus.regEnable = r_reg_en;
                bus.a_select  = r_a_sel;
                bus.b_select  = r_b_sel;
                bus.use_imm   = r_use_imm;
                bus.immediate = r_imm;
                bus.opCode    = {4'h0, r_func};
                w_next_state  = S_DONE;
            end
            S_DONE: begin
                bus.done     = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign bus.err     = r_err;
    assign bus.retired = r_retired;

endmodule
